// File: rtl/mem_bridge_if.sv
// Signal bundle between the CPU load/store logic, the 8-bit memory bus and mem_bridge.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface mem_bridge_if;
  logic        ready;
  logic        io_ioBufferFull;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_write;
  logic [1:0]  io_req_size;
  logic        io_req_signed;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_data;
  logic        io_resp_valid;
  logic [31:0] io_resp_data;
  logic [31:0] io_ram_address;
  logic [7:0]  io_ram_dataOut;
  logic        io_ram_writeEnable;
  logic [7:0]  io_ram_dataIn;

  modport slave (
    input  ready, io_ioBufferFull,
    input  io_req_valid, io_req_write, io_req_size, io_req_signed, io_req_addr, io_req_data,
    output io_req_ready, io_resp_valid, io_resp_data,
    output io_ram_address, io_ram_dataOut, io_ram_writeEnable,
    input  io_ram_dataIn
  );

  modport master (
    output ready, io_ioBufferFull,
    output io_req_valid, io_req_write, io_req_size, io_req_signed, io_req_addr, io_req_data,
    input  io_req_ready, io_resp_valid, io_resp_data,
    input  io_ram_address, io_ram_dataOut, io_ram_writeEnable,
    output io_ram_dataIn
  );
endinterface

// File: rtl/mem_bridge.sv
// Byte-serial initiator: splits one byte/half/word request into little-endian single-byte
// bus transactions, honouring the bus grant and the I/O buffer-full flag.
module mem_bridge #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input logic      clock,
  input logic      reset,
  mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_last;
  logic [2:0]  r_idx;
  logic        r_signed;
  logic        r_io;
  logic        r_cap;
  logic [1:0]  r_lane;
  logic        r_we;
  logic [7:0]  r_dout;
  logic [31:0] r_ram_addr;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;

  logic        w_req_io;
  logic [1:0]  w_size_last;
  logic        w_rd_issue;
  logic        w_rd_done;
  logic        w_wr_issue;
  logic        w_wr_done;
  logic [2:0]  w_next_idx;
  logic [31:0] w_next_addr;
  logic [7:0]  w_next_byte;
  logic [31:0] w_rd_word;
  logic [31:0] w_rd_result;

  assign w_req_io    = (bus.io_req_addr[17:16] == IO_HI);
  assign w_size_last = (bus.io_req_size == 2'd0) ? 2'd0 :
                       (bus.io_req_size == 2'd1) ? 2'd1 : 2'd3;

  assign w_rd_issue  = (r_state == S_READ) && (r_idx <= {1'b0, r_last}) && bus.ready;
  assign w_rd_done   = (r_state == S_READ) && r_cap && (r_lane == r_last);
  assign w_wr_issue  = (r_state == S_WRITE) && r_we && bus.ready;
  assign w_wr_done   = w_wr_issue && (r_idx[1:0] == r_last);

  assign w_next_idx  = r_idx + 3'd1;
  assign w_next_addr = r_addr + {29'd0, w_next_idx};
  assign w_next_byte = r_wdata[{w_next_idx[1:0], 3'b000} +: 8];
  assign w_rd_word   = r_rdata | ({24'd0, bus.io_ram_dataIn} << {r_lane, 3'b000});

  always_comb begin
    w_rd_result = w_rd_word;
    case (r_last)
      2'd0:    w_rd_result = {{24{r_signed & w_rd_word[7]}},  w_rd_word[7:0]};
      2'd1:    w_rd_result = {{16{r_signed & w_rd_word[15]}}, w_rd_word[15:0]};
      default: w_rd_result = w_rd_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.io_req_valid) w_state_next = bus.io_req_write ? S_WRITE : S_READ;
      S_READ:  if (w_rd_done)        w_state_next = S_IDLE;
      S_WRITE: if (w_wr_done)        w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // Write enable is registered, so the I/O full flag seen this cycle gates next cycle's
  // strobe; after an issued I/O byte the flag is stale for one cycle, hence the forced gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_last       <= '0;
      r_idx        <= '0;
      r_signed     <= 1'b0;
      r_io         <= 1'b0;
      r_cap        <= 1'b0;
      r_lane       <= '0;
      r_we         <= 1'b0;
      r_dout       <= '0;
      r_ram_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.io_req_valid) begin
            r_addr     <= bus.io_req_addr;
            r_wdata    <= bus.io_req_data;
            r_last     <= w_size_last;
            r_signed   <= bus.io_req_signed;
            r_io       <= w_req_io;
            r_idx      <= '0;
            r_rdata    <= '0;
            r_cap      <= 1'b0;
            r_ram_addr <= bus.io_req_addr;
            if (bus.io_req_write) begin
              r_dout <= bus.io_req_data[7:0];
              r_we   <= !(w_req_io && bus.io_ioBufferFull);
            end
          end
        end
        S_READ: begin
          if (r_cap) r_rdata <= w_rd_word;
          if (w_rd_issue) begin
            r_cap  <= 1'b1;
            r_lane <= r_idx[1:0];
            r_idx  <= w_next_idx;
            if (r_idx[1:0] != r_last) r_ram_addr <= w_next_addr;
          end else begin
            r_cap <= 1'b0;
          end
          if (w_rd_done) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rd_result;
          end
        end
        S_WRITE: begin
          if (w_wr_done) begin
            r_we         <= 1'b0;
            r_dout       <= '0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
          end else if (w_wr_issue) begin
            r_idx      <= w_next_idx;
            r_ram_addr <= w_next_addr;
            r_dout     <= w_next_byte;
            r_we       <= !r_io;
          end else begin
            r_we <= !(r_io && bus.io_ioBufferFull);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.io_req_ready       = (r_state == S_IDLE);
  assign bus.io_resp_valid      = r_resp_valid;
  assign bus.io_resp_data       = r_resp_data;
  assign bus.io_ram_address     = r_ram_addr;
  assign bus.io_ram_dataOut     = r_dout;
  assign bus.io_ram_writeEnable = r_we;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: a byte-array RAM model plus a per-request reference that derives
// issue cycles, bus values and results from the ready/full patterns and RAM contents.
module tb_mem_bridge;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   wr_count = 0;
  int   wr_cycles[$];
  logic [7:0] mem [0:131071];

  mem_bridge_if bus_if();

  mem_bridge #(.IO_HI(2'b11)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // RAM read port: data for the address driven in a cycle appears in the next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus_if.io_ram_dataIn <= mem[bus_if.io_ram_address[16:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The RAM commits a byte at the end of a granted cycle with the strobe high.
  task automatic bus_write_model();
    if (!rst && bus_if.ready && bus_if.io_ram_writeEnable) begin
      mem[bus_if.io_ram_address[16:0]] = bus_if.io_ram_dataOut;
      wr_count++;
      wr_cycles.push_back(cyc);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus_if.io_req_valid    = 1'b0;
    bus_if.ready           = 1'b1;
    bus_if.io_ioBufferFull = 1'b0;
    bus_write_model();
  endtask

  // Called at a negedge; that cycle is cycle 0 (accept). Returns the response cycle or -1.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [63:0] rdy, input logic [63:0] full, output int resp_cyc);
    int n, idx, last_iss, wr0;
    logic io, prev_iss, iss, exp_we, resp_now, done;
    logic [31:0] exp_data, a;
    longint v;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    io = wr && (addr[17:16] == 2'b11);
    v  = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v = v | (longint'(mem[a[16:0]]) << (8 * i));
    end
    if (sgn && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    exp_data = wr ? 32'd0 : v[31:0];
    wr0 = wr_count;

    bus_if.io_req_valid    = 1'b1;
    bus_if.io_req_write    = wr;
    bus_if.io_req_size     = size;
    bus_if.io_req_signed   = sgn;
    bus_if.io_req_addr     = addr;
    bus_if.io_req_data     = data;
    bus_if.ready           = rdy[0];
    bus_if.io_ioBufferFull = full[0];
    check("req_ready_accept", 32'(bus_if.io_req_ready), 32'd1);

    idx = 0; prev_iss = 1'b0; last_iss = -10; resp_cyc = -1; done = 1'b0;
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk);
      bus_if.io_req_valid    = 1'b0;
      bus_if.ready           = rdy[c];
      bus_if.io_ioBufferFull = full[c];
      if (idx < n) begin
        exp_we = wr ? (io ? (!full[c-1] && !prev_iss) : 1'b1) : 1'b0;
        iss    = (wr ? exp_we : 1'b1) && rdy[c];
      end else begin
        exp_we = 1'b0;
        iss    = 1'b0;
      end
      resp_now = (idx == n) && (c == last_iss + (wr ? 1 : 2));
      check("resp_valid", 32'(bus_if.io_resp_valid), 32'(resp_now));
      check("req_ready", 32'(bus_if.io_req_ready), 32'(resp_now));
      check("write_enable", 32'(bus_if.io_ram_writeEnable), 32'(exp_we));
      if (idx < n) begin
        check("address", bus_if.io_ram_address, addr + 32'(idx));
        check("data_out", 32'(bus_if.io_ram_dataOut), wr ? ((data >> (8 * idx)) & 32'hFF) : 32'd0);
      end else begin
        check("data_out_idle", 32'(bus_if.io_ram_dataOut), 32'd0);
      end
      bus_write_model();
      if (resp_now) begin
        check("resp_data", bus_if.io_resp_data, exp_data);
        resp_cyc = c;
        done = 1'b1;
      end
      prev_iss = iss;
      if (iss) begin
        idx++;
        last_iss = c;
      end
    end
    check("resp_seen", 32'(done), 32'd1);
    check("write_count", 32'(wr_count - wr0), wr ? 32'(n) : 32'd0);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        check("stored_byte", 32'(mem[a[16:0]]), (data >> (8 * i)) & 32'hFF);
      end
    end
  endtask

  initial begin
    int rc, g0, w0;
    logic [31:0] ra, rd;
    logic [63:0] rr, rf;
    logic rw, rs;
    logic [1:0] rz;

    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    bus_if.ready = 1'b1;
    bus_if.io_ioBufferFull = 1'b0;
    bus_if.io_req_valid = 1'b0;
    bus_if.io_req_write = 1'b0;
    bus_if.io_req_size = 2'd0;
    bus_if.io_req_signed = 1'b0;
    bus_if.io_req_addr = '0;
    bus_if.io_req_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus_if.io_req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus_if.io_resp_valid), 32'd0);
    check("rst_resp_data", bus_if.io_resp_data, 32'd0);
    check("rst_address", bus_if.io_ram_address, 32'd0);
    check("rst_data_out", 32'(bus_if.io_ram_dataOut), 32'd0);
    check("rst_write_enable", 32'(bus_if.io_ram_writeEnable), 32'd0);
    rst = 1'b0;

    // Word load, no stalls
    mem[17'h100] = 8'h78; mem[17'h101] = 8'h56; mem[17'h102] = 8'h34; mem[17'h103] = 8'h12;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, '1, '0, rc);
    check("word_load_cycle", 32'(rc), 32'd6);
    check("word_load_value", bus_if.io_resp_data, 32'h12345678);
    idle_cycle();

    // Byte loads, signed and unsigned
    mem[17'h101] = 8'h80;
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'd0, '1, '0, rc);
    check("sbyte_value", bus_if.io_resp_data, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, '1, '0, rc);
    check("ubyte_value", bus_if.io_resp_data, 32'h00000080);
    mem[17'h100] = 8'h34; mem[17'h101] = 8'h92;
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'd0, '1, '0, rc);
    check("shalf_value", bus_if.io_resp_data, 32'hFFFF9234);

    // Word store crossing a 256-byte boundary
    do_req(1'b1, 2'd2, 1'b0, 32'h1FF, 32'hDEADBEEF, '1, '0, rc);
    check("word_store_cycle", 32'(rc), 32'd5);
    check("store_resp_zero", bus_if.io_resp_data, 32'd0);
    check("store_byte_202", 32'(mem[17'h202]), 32'hDE);

    // I/O byte store held off by buffer-full in cycles 0..9
    idle_cycle();
    do_req(1'b1, 2'd0, 1'b0, 32'h30000, 32'h5A, '1, 64'h3FF, rc);
    check("io_full_resp_cycle", 32'(rc), 32'd12);

    // Back-to-back I/O byte stores leave a gap on the bus
    do_req(1'b1, 2'd0, 1'b0, 32'h30001, 32'hA5, '1, '0, rc);
    w0 = wr_cycles[$];
    do_req(1'b1, 2'd0, 1'b0, 32'h30002, 32'h3C, '1, '0, rc);
    check("io_write_gap", 32'((wr_cycles[$] - w0) >= 2), 32'd1);

    // I/O word store: a forced idle cycle after every issued byte
    do_req(1'b1, 2'd2, 1'b0, 32'h30004, 32'h11223344, '1, '0, rc);
    check("io_word_cycle", 32'(rc), 32'd8);

    // Word load with bus grant removed in cycles 2-4
    mem[17'h100] = 8'h78; mem[17'h101] = 8'h56; mem[17'h102] = 8'h34; mem[17'h103] = 8'h12;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, ~64'h1C, '0, rc);
    check("paused_load_cycle", 32'(rc), 32'd9);
    check("paused_load_value", bus_if.io_resp_data, 32'h12345678);

    // Word load wrapping past 2^32; size 3 behaves as a word
    do_req(1'b0, 2'd3, 1'b1, 32'hFFFFFFFE, 32'd0, '1, '0, rc);
    check("wrap_load_cycle", 32'(rc), 32'd6);

    // Reset in cycle 3 of a word store aborts it
    idle_cycle();
    for (int i = 0; i < 4; i++) mem[17'h400 + 17'(i)] = 8'h00;
    g0 = wr_count;
    bus_if.io_req_valid = 1'b1;
    bus_if.io_req_write = 1'b1;
    bus_if.io_req_size  = 2'd2;
    bus_if.io_req_addr  = 32'h400;
    bus_if.io_req_data  = 32'hA1B2C3D4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus_if.io_req_valid = 1'b0;
      if (c == 3) rst = 1'b1;
      bus_write_model();
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort_write_enable", 32'(bus_if.io_ram_writeEnable), 32'd0);
    check("abort_req_ready", 32'(bus_if.io_req_ready), 32'd1);
    check("abort_address", bus_if.io_ram_address, 32'd0);
    check("abort_resp_data", bus_if.io_resp_data, 32'd0);
    bus_write_model();
    for (int c = 0; c < 4; c++) begin
      check("abort_no_resp", 32'(bus_if.io_resp_valid), 32'd0);
      idle_cycle();
    end
    check("abort_write_count", 32'(wr_count - g0), 32'd2);
    check("abort_byte0", 32'(mem[17'h400]), 32'hD4);
    check("abort_byte1", 32'(mem[17'h401]), 32'hC3);
    check("abort_byte2", 32'(mem[17'h402]), 32'h00);

    // Randomized requests against the reference
    for (int k = 0; k < 60; k++) begin
      rw = 1'($urandom);
      rz = 2'($urandom);
      rs = 1'($urandom);
      rd = $urandom;
      case ($urandom_range(0, 3))
        0:       ra = 32'h30000 + 32'($urandom_range(0, 7));
        1:       ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: ra = $urandom & 32'h1FFFF;
      endcase
      rr = {40'hFF_FFFF_FFFF, 24'($urandom | $urandom)};
      rf = {40'd0, 24'($urandom & $urandom)};
      do_req(rw, rz, rs, ra, rd, rr, rf, rc);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_bridge.md
# mem_bridge

Byte-serial memory-bus initiator between the CPU core's load/store/fetch logic and the top-level 8-bit memory bus (the 128 KiB RAM plus the host-communication I/O window at 0x30000–0x30007). It accepts one word/half/byte request at a time and sequences it into single-byte bus transactions: little-endian, with one-cycle read latency. It honours the top-level `ready` pause and the I/O buffer-full flag, and returns a zero- or sign-extended 32-bit result.

## Interface
Parameters:
- `IO_HI`, default 2'b11: value of `addr[17:16]` selecting the I/O window.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ready`  in  1  bus grant; 0 means the host interface owns the bus and the block must pause.
- `io_ioBufferFull`  in  1  I/O output buffer full.
- `io_req_valid`  in  1  request present.
- `io_req_ready`  out  1  block idle and able to accept a request.
- `io_req_write`  in  1  1 = store, 0 = load.
- `io_req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `io_req_signed`  in  1  loads only; sign-extend the result.
- `io_req_addr`  in  32  byte address of the first byte.
- `io_req_data`  in  32  store data; bits [8N-1:0] are used.
- `io_resp_valid`  out  1  one-cycle completion pulse.
- `io_resp_data`  out  32  load result; 0 for stores.
- `io_ram_address`  out  32  bus byte address.
- `io_ram_dataOut`  out  8  bus write byte.
- `io_ram_writeEnable`  out  1  bus write strobe.
- `io_ram_dataIn`  in  8  bus read byte, valid one cycle after its address is issued.

## Operation
- States: IDLE, READ, WRITE.
- IDLE: `io_req_ready` = 1. On `io_req_valid`, latch the request and set N = 1/2/4 bytes. Go to READ or WRITE.
- Byte i (0-based) uses address `addr+i`. Addition is 32-bit and wraps at 2^32. Misaligned addresses are legal. Byte i of the data is bits [8i+7:8i].
- A byte is *issued* in a cycle where its address is driven and `ready` = 1. A cycle with `ready` = 0 issues nothing: hold the address/data/index and re-present next cycle. `io_ram_writeEnable` is registered and may be high while `ready` = 0; the top-level mux ignores it.
- READ: issue bytes back-to-back. In the cycle after an issue, capture `io_ram_dataIn` into byte lane i. Never capture after a non-issue cycle. Each byte is issued exactly once; I/O reads have side effects.
- After the last capture, the result is zero-extended, or sign-extended from bit 8N-1 when `signed` = 1. Pulse `io_resp_valid`, then return to IDLE.
- WRITE: drive address, data byte and `io_ram_writeEnable` = 1 for each byte. Advance on issue.
- WRITE, I/O region (`addr[17:16]` == `IO_HI`): do not issue while `io_ioBufferFull` = 1, or in the cycle directly after a previous issued I/O write, because the full flag lags one cycle. Hold `io_ram_writeEnable` = 0 while stalled.
- After the last issued byte: pulse `io_resp_valid` with `io_resp_data` = 0, then return to IDLE.
- Not in WRITE: `io_ram_writeEnable` = 0 and `io_ram_dataOut` = 0.
- Reset at any time, including mid-transfer: abort with no completion pulse. All outputs take reset values from the cycle after reset is sampled.
- Reset values: `io_req_ready` = 1, `io_resp_valid` = 0, `io_resp_data` = 0, `io_ram_address` = 0, `io_ram_dataOut` = 0, `io_ram_writeEnable` = 0. State = IDLE.

## Timing
- Cycle 0 ends with the accepting edge. With no stalls, byte i is driven in cycle i+1.
- Store: bytes in cycles 1..N; `io_resp_valid` in cycle N+1; a new request can be accepted at the end of cycle N+1.
- Load: addresses in cycles 1..N; last data captured at the end of cycle N+1; `io_resp_valid` in cycle N+2. Word load latency is 6 cycles.
- Every `ready` = 0 cycle or I/O stall cycle adds exactly one cycle.
- `io_req_ready` = 0 from cycle 1 until the response cycle.
- `io_resp_data` holds its value until the next response.

## Test plan
- RAM[0x100..0x103] = 78 56 34 12; word load at 0x100 -> `io_resp_data` = 0x12345678, `io_resp_valid` in cycle 6, addresses 0x100–0x103 in cycles 1–4.
- RAM[0x101] = 0x80: signed byte load -> 0xFFFFFF80. Unsigned -> 0x00000080. Signed half load at 0x100 with bytes 0x34,0x92 -> 0xFFFF9234.
- Word store 0xDEADBEEF at 0x1FF -> bytes EF/BE/AD/DE written to 0x1FF/0x200/0x201/0x202, `io_resp_valid` in cycle 5.
- Byte store to 0x30000 with `io_ioBufferFull` = 1 for 10 cycles -> `io_ram_writeEnable` stays 0, then writes in the first cycle after full drops. Two back-to-back I/O byte stores -> at least one idle bus cycle between the writes.
- Word load with `ready` = 0 in cycles 2–4 -> each address issued once, result 0x12345678, `io_resp_valid` in cycle 9.
- Reset asserted in cycle 3 of a word store -> `io_ram_writeEnable` = 0 and `io_req_ready` = 1 next cycle, no `io_resp_valid`, only bytes 0–1 written.
